fifo_rd_packer: RTL and testbench

FIFO_RD_PACKER -- requirements
Module: fifo_rd_packer

---
 rtl/fifo_rd_packer_pkg.sv | 23 ++
 rtl/fifo_rd_packer.sv | 84 ++++++++
 tb/tb_fifo_rd_packer.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_rd_packer_pkg.sv
// Shared definitions for the FIFO read packer: state encoding, word geometry
// and counter widths.
package fifo_rd_packer_pkg;

  typedef enum logic [1:0] {
    ST_RD  = 2'd0,
    ST_CK  = 2'd1,
    ST_BK  = 2'd2,
    ST_OUT = 2'd3
  } state_t;

  localparam int BYTES_PER_WORD_C = 4;
  localparam int STALL_W          = 8;
  localparam int BK_W             = 4;

  // Increment that holds at the all-ones value instead of wrapping.
  function automatic logic [STALL_W-1:0] sat_inc(input logic [STALL_W-1:0] v);
    logic [STALL_W-1:0] one;
    one = {{(STALL_W-1){1'b0}}, 1'b1};
    return (v == {STALL_W{1'b1}}) ? v : v + one;
  endfunction

endpackage

// File: rtl/fifo_rd_packer.sv
// Drains an upstream byte FIFO one byte every two cycles and packs the bytes
// little-endian into 32-bit words. Empty responses trigger a short backoff so
// the producer gets write slots; a word waiting for acceptance stops the drain.
//
// state | meaning
// RD    | read request issued to the FIFO this cycle
// CK    | FIFO response visible: capture byte or count an empty
// BK    | backoff after an empty response, FIFO free to take writes
// OUT   | complete word presented, waiting for word_ready
module fifo_rd_packer
  import fifo_rd_packer_pkg::*;
#(
  parameter int BACKOFF        = 2,
  parameter int BYTES_PER_WORD = BYTES_PER_WORD_C
) (
  input  logic               clk,
  input  logic               rst,
  output logic               fifo_ren,
  input  logic [7:0]         fifo_dout,
  input  logic               fifo_error,
  output logic [31:0]        word_out,
  output logic               word_valid,
  input  logic               word_ready,
  output logic [STALL_W-1:0] stall_cnt
);

  localparam logic [1:0]      LAST_LANE = 2'(BYTES_PER_WORD - 1);
  localparam logic [BK_W-1:0] BK_LOAD   = BK_W'(BACKOFF - 1);

  state_t          state;
  logic [1:0]      idx;
  logic [BK_W-1:0] bk_cnt;

  // Read strobe is a pure state decode; held low while reset is asserted.
  assign fifo_ren   = (state == ST_RD) && !rst;
  assign word_valid = (state == ST_OUT);

  // Sequencer: read/check alternation, backoff timer, lane packing and stall count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_RD;
      idx       <= '0;
      bk_cnt    <= '0;
      word_out  <= '0;
      stall_cnt <= '0;
    end else begin
      case (state)
        ST_RD: state <= ST_CK;
        ST_CK: begin
          if (fifo_error) begin
            stall_cnt <= sat_inc(stall_cnt);
            bk_cnt    <= BK_LOAD;
            state     <= ST_BK;
          end else begin
            word_out[{idx, 3'b000} +: 8] <= fifo_dout;
            // The last lane keeps idx at its top value; it only returns to
            // zero when the word is accepted, never by overflow.
            if (idx == LAST_LANE) begin
              state <= ST_OUT;
            end else begin
              idx   <= idx + 2'd1;
              state <= ST_RD;
            end
          end
        end
        ST_BK: begin
          if (bk_cnt == '0) begin
            state <= ST_RD;
          end else begin
            bk_cnt <= bk_cnt - 1'b1;
          end
        end
        ST_OUT: begin
          if (word_ready) begin
            idx   <= '0;
            state <= ST_RD;
          end
        end
        default: state <= ST_RD;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Self-checking bench for fifo_rd_packer: behavioural 8-entry byte FIFO with
// read-over-write priority, and a word scoreboard fed as bytes are pushed.
module tb_fifo_rd_packer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        fifo_ren;
  logic [7:0]  fifo_dout = 8'h00;
  logic        fifo_error = 1'b0;
  logic [31:0] word_out;
  logic        word_valid;
  logic        word_ready = 1'b0;
  logic [7:0]  stall_cnt;

  int checks = 0;
  int errors = 0;

  logic [7:0]  fifo_q[$];
  logic [7:0]  wr_pend[$];
  logic [31:0] exp_q[$];
  logic [31:0] acc;
  int          acc_n;

  fifo_rd_packer #(.BACKOFF(2), .BYTES_PER_WORD(4)) dut (
    .clk(clk), .rst(rst), .fifo_ren(fifo_ren), .fifo_dout(fifo_dout),
    .fifo_error(fifo_error), .word_out(word_out), .word_valid(word_valid),
    .word_ready(word_ready), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  // Upstream FIFO: a read wins the cycle; writes land only in non-read cycles.
  always @(posedge clk) begin
    if (fifo_ren) begin
      if (fifo_q.size() == 0) begin
        fifo_error <= 1'b1;
      end else begin
        fifo_dout  <= fifo_q.pop_front();
        fifo_error <= 1'b0;
      end
    end else begin
      fifo_error <= 1'b0;
      if (wr_pend.size() > 0 && fifo_q.size() < 8) fifo_q.push_back(wr_pend.pop_front());
    end
  end

  // Word scoreboard: compare every accepted word against the packed bytes.
  always @(negedge clk) begin
    if (!rst && word_valid && word_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL word_unexpected got=%h expected=none", word_out);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        if (word_out !== e) begin
          errors++;
          $display("FAIL word_data got=%h expected=%h", word_out, e);
        end
      end
    end
  end

  task automatic push_byte(input logic [7:0] b);
    wr_pend.push_back(b);
    acc[acc_n*8 +: 8] = b;
    acc_n++;
    if (acc_n == 4) begin
      exp_q.push_back(acc);
      acc_n = 0;
      acc   = '0;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Enter reset and drop all bench-side FIFO and scoreboard state.
  task automatic do_reset(input int cycles);
    rst = 1'b1;
    fifo_q.delete();
    wr_pend.delete();
    exp_q.delete();
    acc   = '0;
    acc_n = 0;
    repeat (cycles) step();
  endtask

  task automatic release_reset();
    rst = 1'b0;
    #1;
  endtask

  task automatic wait_valid(input int budget, output int n, output bit found);
    n = 0;
    while (!word_valid && n < budget) begin
      step();
      n++;
    end
    found = word_valid;
  endtask

  task automatic test_reset();
    #2;
    rst = 1'b1;
    #1;
    checks++; if (fifo_ren !== 1'b0) begin errors++; $display("FAIL rst_ren got=%b expected=0", fifo_ren); end
    checks++; if (word_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got=%b expected=0", word_valid); end
    checks++; if (word_out !== 32'h0) begin errors++; $display("FAIL rst_word got=%h expected=0", word_out); end
    checks++; if (stall_cnt !== 8'h0) begin errors++; $display("FAIL rst_stall got=%0d expected=0", stall_cnt); end
  endtask

  task automatic test_single_word();
    int ren_cnt, vld_cnt, first_vld;
    do_reset(6);
    push_byte(8'h11); push_byte(8'h22); push_byte(8'h33); push_byte(8'h44);
    repeat (6) step();
    word_ready = 1'b1;
    release_reset();
    ren_cnt = 0; vld_cnt = 0; first_vld = 0;
    for (int c = 1; c <= 12; c++) begin
      if (c <= 9 && fifo_ren) ren_cnt++;
      if (word_valid) begin
        vld_cnt++;
        if (first_vld == 0) first_vld = c;
      end
      step();
    end
    checks++; if (ren_cnt != 4) begin errors++; $display("FAIL single_ren_pulses got=%0d expected=4", ren_cnt); end
    checks++; if (first_vld != 9) begin errors++; $display("FAIL single_valid_cycle got=%0d expected=9", first_vld); end
    checks++; if (vld_cnt != 1) begin errors++; $display("FAIL single_valid_len got=%0d expected=1", vld_cnt); end
  endtask

  task automatic test_backoff();
    logic [19:0] got, exp;
    do_reset(3);
    release_reset();
    for (int c = 1; c <= 20; c++) begin
      got[c-1] = fifo_ren;
      exp[c-1] = ((c % 4) == 1);
      step();
    end
    checks++; if (got !== exp) begin errors++; $display("FAIL backoff_ren_pattern got=%b expected=%b", got, exp); end
    checks++; if (stall_cnt !== 8'd5) begin errors++; $display("FAIL backoff_stall got=%0d expected=5", stall_cnt); end
  endtask

  task automatic test_bk_write();
    do_reset(3);
    release_reset();
    step();
    step();
    push_byte(8'hA5);
    repeat (4) step();
    checks++; if (word_out[7:0] !== 8'hA5) begin errors++; $display("FAIL bkwrite_lane0 got=%h expected=a5", word_out[7:0]); end
    checks++; if (stall_cnt !== 8'd1) begin errors++; $display("FAIL bkwrite_stall got=%0d expected=1", stall_cnt); end
    checks++; if (fifo_ren !== 1'b1) begin errors++; $display("FAIL bkwrite_next_rd got=%b expected=1", fifo_ren); end
  endtask

  task automatic test_backpressure();
    int n;
    bit found, hold_ok;
    logic [31:0] held;
    do_reset(2);
    word_ready = 1'b0;
    for (int i = 1; i <= 8; i++) push_byte(8'(i));
    repeat (10) step();
    release_reset();
    wait_valid(30, n, found);
    checks++; if (!found) begin errors++; $display("FAIL bp_first_valid got=timeout expected=valid"); end
    held = word_out;
    hold_ok = 1'b1;
    for (int c = 0; c < 10; c++) begin
      step();
      if (word_out !== held || word_valid !== 1'b1 || fifo_ren !== 1'b0) hold_ok = 1'b0;
    end
    checks++; if (!hold_ok) begin errors++; $display("FAIL bp_hold got=%h/%b/%b expected=%h/1/0", word_out, word_valid, fifo_ren, held); end
    word_ready = 1'b1;
    step();
    wait_valid(30, n, found);
    checks++; if (!found || n != 8) begin errors++; $display("FAIL bp_second_latency got=%0d expected=8", n); end
    step();
  endtask

  task automatic test_reset_mid();
    int n;
    bit found;
    do_reset(2);
    word_ready = 1'b1;
    push_byte(8'hDE); push_byte(8'hAD); push_byte(8'hBE);
    repeat (5) step();
    release_reset();
    repeat (5) step();
    checks++; if (word_out[15:0] !== 16'hADDE) begin errors++; $display("FAIL mid_partial got=%h expected=adde", word_out[15:0]); end
    rst = 1'b1;
    #1;
    checks++; if (word_out !== 32'h0 || fifo_ren !== 1'b0 || word_valid !== 1'b0) begin
      errors++; $display("FAIL mid_async_clear got=%h/%b/%b expected=0/0/0", word_out, fifo_ren, word_valid);
    end
    do_reset(2);
    push_byte(8'h5A); push_byte(8'h6B); push_byte(8'h7C); push_byte(8'h8D);
    repeat (6) step();
    release_reset();
    wait_valid(30, n, found);
    checks++; if (!found) begin errors++; $display("FAIL mid_new_word got=timeout expected=valid"); end
    step();
  endtask

  task automatic test_saturate();
    do_reset(2);
    release_reset();
    repeat (1000) step();
    checks++; if (stall_cnt !== 8'd250) begin errors++; $display("FAIL sat_midway got=%0d expected=250", stall_cnt); end
    repeat (210) step();
    checks++; if (stall_cnt !== 8'd255) begin errors++; $display("FAIL sat_hold got=%0d expected=255", stall_cnt); end
  endtask

  task automatic test_stream();
    int n;
    do_reset(2);
    release_reset();
    for (int i = 0; i < 16; i++) begin
      push_byte(8'($urandom));
      repeat ($urandom_range(1, 6)) begin
        word_ready = ($urandom_range(0, 3) != 0);
        step();
      end
    end
    n = 0;
    while (exp_q.size() != 0 && n < 600) begin
      word_ready = ($urandom_range(0, 3) != 0);
      step();
      n++;
    end
    word_ready = 1'b1;
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL stream_drain got=%0d expected=0 words left", exp_q.size()); end
  endtask

  initial begin
    acc = '0;
    acc_n = 0;
    test_reset();
    test_single_word();
    test_backoff();
    test_bk_write();
    test_backpressure();
    test_reset_mid();
    test_saturate();
    test_stream();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
